// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
//   Types and constants shared by the AXI4-Lite master and slave blocks.
//   resp_t          : 2-bit AXI response code, with its four named values
//   rd_mst_state_t  : read-initiator state encoding (IDLE, ADDR, DATA, RESP)
// ---------------------------------------------------------------------------
package axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } rd_mst_state_t;

endpackage

// File: rtl/axil_timeout_cnt.sv
// ---------------------------------------------------------------------------
// axil_timeout_cnt
//   Cycle counter that flags when TIMEOUT_CYCLES enabled cycles have elapsed
//   since the last clear. TIMEOUT_CYCLES = 0 removes the counter entirely and
//   ties expired low.
// Ports:
//   CLK     in  clock, rising edge
//   RSTn    in  synchronous active-low reset
//   clear   in  restart the count at zero (has priority over enable)
//   enable  in  count this cycle
//   expired out high while the current cycle is the TIMEOUT_CYCLES-th
//               enabled cycle since the last clear
// ---------------------------------------------------------------------------
module axil_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = CLK ^ RSTn ^ clear ^ enable;
            assign expired       = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            // NOTE: registers are written with non-blocking assignments so all
            // flops update together from pre-edge values.
            always_ff @(posedge CLK) begin
                if (!RSTn) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != LAST)) begin
                    // Saturating at LAST keeps the counter from wrapping if
                    // the user holds enable past expiry.
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/axil_rd_master.sv
// ---------------------------------------------------------------------------
// axil_rd_master
//   AXI4-Lite read initiator: turns one local request into one AR + R
//   transaction, one outstanding at a time, with an optional R-channel
//   timeout. After a timeout the block keeps RREADY high (drain) and refuses
//   new requests until the late beat arrives, so that beat can never be
//   credited to a later request. Every output is a flop.
// Ports:
//   CLK, RSTn                 clock / synchronous active-low reset
//   req_valid/req_ready       local request handshake, req_addr = address
//   rsp_valid/rsp_ready       local response handshake
//   rsp_data/rsp_resp         read data and AXI response (0 / SLVERR on timeout)
//   rsp_timeout               response was generated by the timeout
//   ARVALID/ARREADY/ARADDR    AXI read address channel
//   RVALID/RREADY/RDATA/RRESP AXI read data channel
// ---------------------------------------------------------------------------
module axil_rd_master
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP
);

    rd_mst_state_t state, state_next;

    logic                  drain;
    logic                  accept, ar_hs, r_hs, rsp_hs;
    logic                  expired, timeout_hit;

    logic                  req_ready_d, arvalid_d, rready_d, rsp_valid_d;
    logic                  rsp_timeout_d, drain_d;
    logic [ADDR_WIDTH-1:0] araddr_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    resp_t                 rsp_resp_d;

    assign accept = req_valid && req_ready;
    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign rsp_hs = rsp_valid && rsp_ready;

    // A beat on the abort cycle wins, hence the !RVALID term.
    assign timeout_hit = (state == DATA) && !RVALID && expired;

    axil_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .clear   (state != DATA),
        .enable  ((state == DATA) && !r_hs),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)              state_next = ADDR;
            ADDR:    if (ar_hs)               state_next = DATA;
            DATA:    if (r_hs || timeout_hit) state_next = RESP;
            RESP:    if (rsp_hs)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        // NOTE: every variable gets a hold-value default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        araddr_d      = ARADDR;
        arvalid_d     = ARVALID;
        rsp_valid_d   = rsp_valid;
        rsp_data_d    = rsp_data;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        drain_d       = drain;

        case (state)
            IDLE: if (accept) begin
                araddr_d  = req_addr;
                arvalid_d = 1'b1;
            end
            ADDR: if (ar_hs) arvalid_d = 1'b0;
            DATA: begin
                if (r_hs) begin
                    rsp_data_d    = RDATA;
                    rsp_resp_d    = RRESP;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else if (timeout_hit) begin
                    rsp_data_d    = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    drain_d       = 1'b1;
                end
            end
            RESP: if (rsp_hs) rsp_valid_d = 1'b0;
            default: ;
        endcase

        // Drain never overlaps DATA (no request is accepted while draining),
        // so any beat seen while draining is the late one and is dropped.
        if (drain && r_hs) drain_d = 1'b0;

        rready_d    = drain_d || (state_next == DATA);
        req_ready_d = (state_next == IDLE) && !drain_d;
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            req_ready   <= 1'b1;
            ARVALID     <= 1'b0;
            ARADDR      <= '0;
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
            drain       <= 1'b0;
        end else begin
            req_ready   <= req_ready_d;
            ARVALID     <= arvalid_d;
            ARADDR      <= araddr_d;
            RREADY      <= rready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_resp    <= rsp_resp_d;
            rsp_timeout <= rsp_timeout_d;
            drain       <= drain_d;
        end
    end

endmodule

// File: tb/tb_axil_rd_master.sv
// ---------------------------------------------------------------------------
// tb_axil_rd_master
//   Self-checking bench for axil_rd_master built with TIMEOUT_CYCLES = 8.
//   A transaction is described by its address, the stall on each channel and
//   the slave's beat; the expected response comes either from a hand-filled
//   table or from a reference function that applies the timeout rule to the
//   beat delay. Reset behaviour is exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_axil_rd_master;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req_valid, req_ready;
    logic [5:0]  req_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        ARVALID, ARREADY;
    logic [5:0]  ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int n_checks = 0;
    int n_fail   = 0;

    axil_rd_master #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (6),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .ARADDR      (ARADDR),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  addr;
        int          ar_delay;   // cycles ARREADY is low while ARVALID is high
        int          r_delay;    // DATA cycles before the RVALID beat
        int          rsp_delay;  // cycles rsp_ready is low while rsp_valid is high
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_to;
    } txn_t;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: a beat arriving within the first TMO DATA cycles (including
    // the TMO-th one) is delivered unchanged; otherwise the request times out.
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        r.exp_to   = (t.r_delay >= TMO);
        r.exp_data = r.exp_to ? 32'h0 : t.rdata;
        r.exp_resp = r.exp_to ? 2'b10 : t.rresp;
        return r;
    endfunction

    // Drives one complete transaction from an idle block and checks every
    // phase cycle by cycle.
    task automatic run_txn(input txn_t t, input string tag);
        int n_data;
        check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = t.addr;
        rsp_ready = 1'b0;
        RVALID    = 1'b0;
        tick();
        req_valid = 1'b0;
        req_addr  = 6'($urandom);

        for (int i = 0; i <= t.ar_delay; i++) begin
            check({tag, ".arvalid"}, 32'(ARVALID), 32'd1);
            check({tag, ".araddr"}, 32'(ARADDR), 32'(t.addr));
            check({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
            ARREADY = (i == t.ar_delay);
            tick();
        end
        ARREADY = 1'b0;
        check({tag, ".arvalid_drop"}, 32'(ARVALID), 32'd0);

        n_data = t.exp_to ? TMO : t.r_delay + 1;
        for (int i = 0; i < n_data; i++) begin
            check({tag, ".rready_data"}, 32'(RREADY), 32'd1);
            check({tag, ".rsp_valid_early"}, 32'(rsp_valid), 32'd0);
            RVALID = (i == t.r_delay);
            RDATA  = (i == t.r_delay) ? t.rdata : $urandom;
            RRESP  = (i == t.r_delay) ? t.rresp : 2'($urandom);
            tick();
        end
        RVALID = 1'b0;
        RDATA  = $urandom;

        for (int i = 0; i <= t.rsp_delay; i++) begin
            check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".rsp_data"}, rsp_data, t.exp_data);
            check({tag, ".rsp_resp"}, 32'(rsp_resp), 32'(t.exp_resp));
            check({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(t.exp_to));
            check({tag, ".rready_resp"}, 32'(RREADY), 32'(t.exp_to));
            check({tag, ".req_ready_resp"}, 32'(req_ready), 32'd0);
            rsp_ready = (i == t.rsp_delay);
            tick();
        end
        rsp_ready = 1'b0;
        check({tag, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);

        if (t.exp_to) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, ".req_ready_drain"}, 32'(req_ready), 32'd0);
                check({tag, ".rready_drain"}, 32'(RREADY), 32'd1);
                if (i < 2) tick();
            end
            // Late beat: must be swallowed, not delivered.
            RVALID = 1'b1;
            RDATA  = $urandom;
            RRESP  = 2'b00;
            tick();
            RVALID = 1'b0;
            check({tag, ".rready_after_drain"}, 32'(RREADY), 32'd0);
            check({tag, ".rsp_valid_after_drain"}, 32'(rsp_valid), 32'd0);
        end
        check({tag, ".req_ready_return"}, 32'(req_ready), 32'd1);
    endtask

    txn_t table_v[7];

    initial begin
        txn_t t;

        // addr, ar_delay, r_delay, rsp_delay, rdata, rresp, exp_data, exp_resp, exp_to
        table_v[0] = '{6'h04, 0,  0, 0, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0}; // basic
        table_v[1] = '{6'h10, 5,  0, 0, 32'hA5A50001, 2'b00, 32'hA5A50001, 2'b00, 1'b0}; // AR stall
        table_v[2] = '{6'h3F, 0,  0, 4, 32'h00001234, 2'b11, 32'h00001234, 2'b11, 1'b0}; // DECERR + backpressure
        table_v[3] = '{6'h08, 0, 20, 1, 32'hFFFFFFFF, 2'b00, 32'h00000000, 2'b10, 1'b1}; // timeout
        table_v[4] = '{6'h0C, 1,  7, 0, 32'hCAFEF00D, 2'b10, 32'hCAFEF00D, 2'b10, 1'b0}; // beat on timeout cycle
        table_v[5] = '{6'h2A, 2,  3, 2, 32'h0BADC0DE, 2'b01, 32'h0BADC0DE, 2'b01, 1'b0}; // EXOKAY
        table_v[6] = '{6'h01, 0,  6, 0, 32'h76543210, 2'b00, 32'h76543210, 2'b00, 1'b0}; // one before boundary

        RSTn      = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RDATA     = '0;
        RRESP     = '0;
        repeat (3) tick();

        check("reset.req_ready",   32'(req_ready),   32'd1);
        check("reset.arvalid",     32'(ARVALID),     32'd0);
        check("reset.araddr",      32'(ARADDR),      32'd0);
        check("reset.rready",      32'(RREADY),      32'd0);
        check("reset.rsp_valid",   32'(rsp_valid),   32'd0);
        check("reset.rsp_data",    rsp_data,         32'd0);
        check("reset.rsp_resp",    32'(rsp_resp),    32'd0);
        check("reset.rsp_timeout", 32'(rsp_timeout), 32'd0);
        RSTn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn(table_v[i], $sformatf("table%0d", i));
        end

        // Reset while ARVALID is waiting for ARREADY.
        check("rst_mid.req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = 6'h15;
        ARREADY   = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_mid.arvalid_before", 32'(ARVALID), 32'd1);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        check("rst_mid.arvalid",   32'(ARVALID),   32'd0);
        check("rst_mid.rready",    32'(RREADY),    32'd0);
        check("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid.req_ready", 32'(req_ready), 32'd1);
        run_txn(model('{6'h22, 0, 1, 0, 32'h13579BDF, 2'b00, 32'h0, 2'b00, 1'b0}), "after_rst");

        // Reset while draining after a timeout.
        run_txn(model('{6'h05, 0, 0, 0, 32'h11112222, 2'b00, 32'h0, 2'b00, 1'b0}), "pre_drain");
        req_valid = 1'b1;
        req_addr  = 6'h30;
        ARREADY   = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        ARREADY = 1'b0;
        repeat (TMO) tick();
        check("drain_rst.timeout", 32'(rsp_timeout), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("drain_rst.req_ready_blocked", 32'(req_ready), 32'd0);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        check("drain_rst.rready",    32'(RREADY),    32'd0);
        check("drain_rst.req_ready", 32'(req_ready), 32'd1);

        // Randomised transactions against the reference function.
        for (int n = 0; n < 24; n++) begin
            t.addr      = 6'($urandom);
            t.ar_delay  = int'($urandom_range(0, 3));
            t.r_delay   = int'($urandom_range(0, TMO + 2));
            t.rsp_delay = int'($urandom_range(0, 3));
            t.rdata     = $urandom;
            t.rresp     = 2'($urandom);
            t.exp_data  = '0;
            t.exp_resp  = '0;
            t.exp_to    = 1'b0;
            run_txn(model(t), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
